// File: rtl/reg_wb_ctrl.sv
// Writeback controller for reg_file's single write port.
// Merges ALU results and in-order load returns onto one registered port, queues
// outstanding load destinations, and keeps a per-register pending-load scoreboard.
module reg_wb_ctrl #(
    parameter int W  = 8,   // data width
    parameter int D  = 4,   // register address width
    parameter int LQ = 2    // load queue depth (max outstanding loads)
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [D-1:0] alu_waddr,
    input  logic [W-1:0] alu_data,
    input  logic         ld_issue,
    output logic         ld_ready,
    input  logic [D-1:0] ld_waddr,
    input  logic         mem_rvalid,
    input  logic [W-1:0] mem_rdata,
    input  logic [D-1:0] raddrA,
    input  logic [D-1:0] raddrB,
    output logic         busy_a,
    output logic         busy_b,
    output logic         write_en,
    output logic [D-1:0] waddr,
    output logic [W-1:0] dataALU_out,
    output logic [W-1:0] dataMem_out,
    output logic         data_source,
    output logic         err_underflow
);

    localparam int NR = 2 ** D;
    localparam int CW = $clog2(LQ + 1);
    localparam int PW = (LQ > 1) ? $clog2(LQ) : 1;

    // Load queue of destination addresses
    logic [D-1:0]  r_q [LQ];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Per-register pending-load counters
    logic [CW-1:0] r_cnt [NR];

    // One-entry skid holding an ALU result displaced by a load return
    logic          r_skid_full;
    logic [D-1:0]  r_skid_addr;
    logic [W-1:0]  r_skid_data;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [D-1:0]  w_head;
    logic          w_alu_xfer;
    logic          w_inc;
    logic          w_dec;
    logic          w_same;

    assign w_full  = (r_count == CW'(LQ));
    assign w_empty = (r_count == '0);
    assign w_head  = r_q[r_rptr];

    // A full queue silently drops ld_issue; a return with nothing queued is an error
    assign w_push  = ld_issue && !w_full;
    assign w_pop   = mem_rvalid && !w_empty;

    // r0 is never tracked, so it never blocks ALU traffic or decode
    assign w_inc   = w_push && (ld_waddr != '0);
    assign w_dec   = w_pop && (w_head != '0);
    assign w_same  = w_inc && w_dec && (ld_waddr == w_head);

    // ALU results wait behind pending loads to the same register to keep write order
    assign alu_ready  = !r_skid_full && !((alu_waddr != '0) && (r_cnt[alu_waddr] != '0));
    assign w_alu_xfer = alu_valid && alu_ready;

    assign ld_ready = !w_full;
    assign busy_a   = (raddrA != '0) && (r_cnt[raddrA] != '0);
    assign busy_b   = (raddrB != '0) && (r_cnt[raddrB] != '0);

    // Queue storage write
    // NOTE: entries are not reset; r_count alone says which ones are meaningful.
    always_ff @(posedge CLK) begin
        if (w_push) r_q[r_wptr] <= ld_waddr;
    end

    // Scoreboard: increment on accepted load, decrement on its return
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NR; i++) r_cnt[i] <= '0;
        end else begin
            if (w_inc && !w_same) r_cnt[ld_waddr] <= r_cnt[ld_waddr] + 1'b1;
            if (w_dec && !w_same) r_cnt[w_head]   <= r_cnt[w_head] - 1'b1;
        end
    end

    // Queue pointers, skid, error flag and arbitrated write port
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_skid_full   <= 1'b0;
            r_skid_addr   <= '0;
            r_skid_data   <= '0;
            err_underflow <= 1'b0;
            write_en      <= 1'b0;
            waddr         <= '0;
            dataALU_out   <= '0;
            dataMem_out   <= '0;
            data_source   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // pre-edge state and later assignments cleanly override defaults.
            if (w_push) r_wptr <= (r_wptr == PW'(LQ - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PW'(LQ - 1)) ? '0 : r_rptr + 1'b1;

            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            if (mem_rvalid && w_empty) err_underflow <= 1'b1;

            write_en <= 1'b0;
            if (w_pop) begin
                write_en    <= (w_head != '0);
                waddr       <= w_head;
                dataMem_out <= mem_rdata;
                data_source <= 1'b1;
                if (w_alu_xfer) begin
                    r_skid_full <= 1'b1;
                    r_skid_addr <= alu_waddr;
                    r_skid_data <= alu_data;
                end
            end else if (r_skid_full) begin
                write_en    <= (r_skid_addr != '0);
                waddr       <= r_skid_addr;
                dataALU_out <= r_skid_data;
                data_source <= 1'b0;
                r_skid_full <= 1'b0;
            end else if (w_alu_xfer) begin
                write_en    <= (alu_waddr != '0);
                waddr       <= alu_waddr;
                dataALU_out <= alu_data;
                data_source <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed testbench for reg_wb_ctrl with W=8, D=4, LQ=2.
module tb_reg_wb_ctrl;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int LQ = 2;

    logic         clk;
    logic         rst_n;
    logic         alu_valid;
    logic         alu_ready;
    logic [D-1:0] alu_waddr;
    logic [W-1:0] alu_data;
    logic         ld_issue;
    logic         ld_ready;
    logic [D-1:0] ld_waddr;
    logic         mem_rvalid;
    logic [W-1:0] mem_rdata;
    logic [D-1:0] raddrA;
    logic [D-1:0] raddrB;
    logic         busy_a;
    logic         busy_b;
    logic         write_en;
    logic [D-1:0] waddr;
    logic [W-1:0] dataALU_out;
    logic [W-1:0] dataMem_out;
    logic         data_source;
    logic         err_underflow;

    int checks   = 0;
    int failures = 0;

    reg_wb_ctrl #(.W(W), .D(D), .LQ(LQ)) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_waddr    (alu_waddr),
        .alu_data     (alu_data),
        .ld_issue     (ld_issue),
        .ld_ready     (ld_ready),
        .ld_waddr     (ld_waddr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .raddrA       (raddrA),
        .raddrB       (raddrB),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .write_en     (write_en),
        .waddr        (waddr),
        .dataALU_out  (dataALU_out),
        .dataMem_out  (dataMem_out),
        .data_source  (data_source),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [D-1:0] a,
                              input logic ds);
        check({tag, ".write_en"},    32'(write_en),    32'(we));
        check({tag, ".waddr"},       32'(waddr),       32'(a));
        check({tag, ".data_source"}, 32'(data_source), 32'(ds));
    endtask

    initial begin
        rst_n      = 1'b0;
        alu_valid  = 1'b0;
        alu_waddr  = '0;
        alu_data   = '0;
        ld_issue   = 1'b0;
        ld_waddr   = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        raddrA     = '0;
        raddrB     = '0;

        // Reset state
        #12;
        check_port("rst", 1'b0, 4'd0, 1'b0);
        check("rst.dataALU_out", 32'(dataALU_out), 32'h0);
        check("rst.dataMem_out", 32'(dataMem_out), 32'h0);
        check("rst.err",         32'(err_underflow), 32'h0);
        check("rst.ld_ready",    32'(ld_ready), 32'h1);
        check("rst.alu_ready",   32'(alu_ready), 32'h1);
        rst_n = 1'b1;
        step();

        // 1: ALU r3=0x5A on an idle port
        alu_valid = 1'b1; alu_waddr = 4'd3; alu_data = 8'h5A;
        #1 check("t1.alu_ready", 32'(alu_ready), 32'h1);
        step();
        alu_valid = 1'b0;
        check_port("t1", 1'b1, 4'd3, 1'b0);
        check("t1.dataALU_out", 32'(dataALU_out), 32'h5A);
        step();
        check_port("t1.idle", 1'b0, 4'd3, 1'b0);
        check("t1.idle.dataALU_out", 32'(dataALU_out), 32'h5A);

        // 2: load r5, busy/alu_ready blocking, return clears busy
        ld_issue = 1'b1; ld_waddr = 4'd5;
        step();
        ld_issue = 1'b0; raddrA = 4'd5; alu_waddr = 4'd5;
        #1;
        check("t2.busy_a",    32'(busy_a),    32'h1);
        check("t2.alu_ready", 32'(alu_ready), 32'h0);
        alu_waddr = 4'd0;
        #1 check("t2.r0_ready", 32'(alu_ready), 32'h1);
        mem_rvalid = 1'b1; mem_rdata = 8'hC3;
        step();
        mem_rvalid = 1'b0;
        check_port("t2.ret", 1'b1, 4'd5, 1'b1);
        check("t2.dataMem_out", 32'(dataMem_out), 32'hC3);
        check("t2.dataALU_hold", 32'(dataALU_out), 32'h5A);
        check("t2.busy_a_clr", 32'(busy_a), 32'h0);

        // 3: load return and ALU transfer collide; ALU goes through the skid
        ld_issue = 1'b1; ld_waddr = 4'd4;
        step();
        ld_issue = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 8'h77;
        alu_valid = 1'b1; alu_waddr = 4'd2; alu_data = 8'h11;
        #1 check("t3.alu_ready0", 32'(alu_ready), 32'h1);
        step();
        mem_rvalid = 1'b0; alu_valid = 1'b0;
        check_port("t3.c1", 1'b1, 4'd4, 1'b1);
        check("t3.c1.dataMem_out", 32'(dataMem_out), 32'h77);
        check("t3.c1.alu_ready", 32'(alu_ready), 32'h0);
        step();
        check_port("t3.c2", 1'b1, 4'd2, 1'b0);
        check("t3.c2.dataALU_out", 32'(dataALU_out), 32'h11);
        check("t3.c2.dataMem_hold", 32'(dataMem_out), 32'h77);
        check("t3.c3.alu_ready", 32'(alu_ready), 32'h1);

        // 4: fill the queue with two loads to r1, third issue ignored
        ld_issue = 1'b1; ld_waddr = 4'd1;
        step();
        check("t4.ready_one", 32'(ld_ready), 32'h1);
        step();
        check("t4.full", 32'(ld_ready), 32'h0);
        ld_waddr = 4'd6;
        step();
        ld_issue = 1'b0; raddrA = 4'd1; raddrB = 4'd6;
        #1;
        check("t4.still_full", 32'(ld_ready), 32'h0);
        check("t4.busy_r1",    32'(busy_a),   32'h1);
        check("t4.r6_dropped", 32'(busy_b),   32'h0);
        mem_rvalid = 1'b1; mem_rdata = 8'h21;
        step();
        check_port("t4.ret1", 1'b1, 4'd1, 1'b1);
        check("t4.ret1.busy", 32'(busy_a), 32'h1);
        check("t4.ret1.ready", 32'(ld_ready), 32'h1);
        mem_rdata = 8'h22;
        step();
        mem_rvalid = 1'b0;
        check("t4.ret2.dataMem", 32'(dataMem_out), 32'h22);
        check("t4.ret2.busy", 32'(busy_a), 32'h0);
        step();
        check("t4.idle.write_en", 32'(write_en), 32'h0);
        check("t4.no_err", 32'(err_underflow), 32'h0);

        // Same-register push and pop in one cycle keeps the register busy
        raddrA = 4'd7;
        ld_issue = 1'b1; ld_waddr = 4'd7;
        step();
        mem_rvalid = 1'b1; mem_rdata = 8'h99;
        step();
        ld_issue = 1'b0; mem_rdata = 8'h9A;
        check_port("pp.ret1", 1'b1, 4'd7, 1'b1);
        check("pp.busy_kept", 32'(busy_a), 32'h1);
        step();
        mem_rvalid = 1'b0;
        check("pp.ret2.dataMem", 32'(dataMem_out), 32'h9A);
        check("pp.busy_clr", 32'(busy_a), 32'h0);

        // 5: r0 writes are suppressed; underflow is sticky
        alu_valid = 1'b1; alu_waddr = 4'd0; alu_data = 8'hFF;
        step();
        alu_valid = 1'b0;
        check_port("t5.alu_r0", 1'b0, 4'd0, 1'b0);
        check("t5.alu_r0.data", 32'(dataALU_out), 32'hFF);
        ld_issue = 1'b1; ld_waddr = 4'd0; raddrA = 4'd0;
        step();
        ld_issue = 1'b0;
        check("t5.r0_not_busy", 32'(busy_a), 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 8'h44;
        step();
        check_port("t5.ld_r0", 1'b0, 4'd0, 1'b1);
        check("t5.ld_r0.dataMem", 32'(dataMem_out), 32'h44);
        check("t5.ld_r0.err", 32'(err_underflow), 32'h0);
        mem_rdata = 8'h55;
        step();
        mem_rvalid = 1'b0;
        check("t5.uf.err", 32'(err_underflow), 32'h1);
        check("t5.uf.write_en", 32'(write_en), 32'h0);
        check("t5.uf.dataMem_hold", 32'(dataMem_out), 32'h44);
        step();
        check("t5.err_sticky", 32'(err_underflow), 32'h1);

        // 6: asynchronous reset mid-cycle with two loads pending
        raddrA = 4'd9; raddrB = 4'd10;
        ld_issue = 1'b1; ld_waddr = 4'd9;
        step();
        ld_waddr = 4'd10;
        alu_valid = 1'b1; alu_waddr = 4'd3; alu_data = 8'h66;
        step();
        ld_issue = 1'b0; alu_valid = 1'b0;
        check_port("t6.pre", 1'b1, 4'd3, 1'b0);
        check("t6.pre.busy_a", 32'(busy_a), 32'h1);
        check("t6.pre.busy_b", 32'(busy_b), 32'h1);
        check("t6.pre.full", 32'(ld_ready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_port("t6.rst", 1'b0, 4'd0, 1'b0);
        check("t6.rst.dataALU", 32'(dataALU_out), 32'h0);
        check("t6.rst.dataMem", 32'(dataMem_out), 32'h0);
        check("t6.rst.err", 32'(err_underflow), 32'h0);
        check("t6.rst.busy_a", 32'(busy_a), 32'h0);
        check("t6.rst.busy_b", 32'(busy_b), 32'h0);
        check("t6.rst.ld_ready", 32'(ld_ready), 32'h1);
        #3 rst_n = 1'b1;
        step();
        check("t6.post.write_en", 32'(write_en), 32'h0);
        check("t6.post.busy_a", 32'(busy_a), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
